// File: rtl/spm_res_unloader.sv
// spm_res_unloader: drains a two-coefficients-per-word result RAM onto a valid/ready stream.
// Define SPM_RES_MODQ_EN to reduce each coefficient once modulo Q on the way out.
module spm_res_unloader #(
  parameter int N = 1024,
  parameter int COEFF_WIDTH = 8,
  parameter int Q = 251
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       ram_rd_en,
  output logic [$clog2(N/2)-1:0]     ram_rd_addr,
  input  logic [2*COEFF_WIDTH-1:0]   ram_data_in,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [COEFF_WIDTH-1:0]     m_data,
  output logic [$clog2(N)-1:0]       m_index,
  output logic                       m_last
);
  localparam int AW = $clog2(N/2);
  typedef enum logic [2:0] {IDLE, RD, CAP, LO, HI, FIN} state_t;
  state_t state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic [2*COEFF_WIDTH-1:0] word;
  logic [COEFF_WIDTH-1:0] coef;
  logic last_word;
  if (N % 2 != 0 || Q < 1) begin : g_param_check
    $error("spm_res_unloader: N must be even and Q positive");
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      word <= '0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      if (state == CAP) word <= ram_data_in;
    end
  end
  always_comb begin
    state_n = state;
    addr_n = addr;
    case (state)
      IDLE: if (start) begin
        state_n = RD;
        addr_n = '0;
      end
      RD:  state_n = CAP;
      CAP: state_n = LO;
      LO:  if (m_ready) state_n = HI;
      HI:  if (m_ready) begin
        state_n = last_word ? FIN : RD;
        addr_n = last_word ? addr : addr + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  assign last_word = addr == AW'(N/2-1);
  assign busy = state inside {RD, CAP, LO, HI};
  assign done = state == FIN;
  assign ram_rd_en = state == RD;
  assign ram_rd_addr = addr;
  assign m_valid = state == LO || state == HI;
  assign m_index = {addr, state == HI};
  assign m_last = state == HI && last_word;
  assign coef = state == HI ? word[2*COEFF_WIDTH-1:COEFF_WIDTH] : word[COEFF_WIDTH-1:0];
`ifdef SPM_RES_MODQ_EN
  localparam logic [COEFF_WIDTH-1:0] QW = COEFF_WIDTH'(Q);
  assign m_data = coef >= QW ? coef - QW : coef;
`else
  assign m_data = coef;
`endif
endmodule

// File: doc/spm_res_unloader.md
SPM_RES_UNLOADER -- requirements
Module: spm_res_unloader

Interface
REQ-001 SHALL have parameter N, default 1024, meaning the polynomial length in coefficients; N SHALL be even.
REQ-002 SHALL have parameter COEFF_WIDTH, default 8, meaning the width of one coefficient in bits.
REQ-003 SHALL have parameter Q, default 251, meaning the coefficient modulus, used only under SPM_RES_MODQ_EN.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start  input  1  single-cycle request to drain the result RAM, normally tied to the multiplier done.
REQ-007 SHALL have port busy  output  1  high from the accepted start until done.
REQ-008 SHALL have port done  output  1  single-cycle pulse after the last coefficient is accepted.
REQ-009 SHALL have port ram_rd_en  output  1  result RAM read enable.
REQ-010 SHALL have port ram_rd_addr  output  clog2(N/2)  result RAM word address.
REQ-011 SHALL have port ram_data_in  input  2*COEFF_WIDTH  result RAM read data, valid one cycle after ram_rd_en; low half is the even coefficient, high half is the odd coefficient.
REQ-012 SHALL have port m_valid  output  1  stream data valid.
REQ-013 SHALL have port m_ready  input  1  stream sink ready.
REQ-014 SHALL have port m_data  output  COEFF_WIDTH  coefficient value.
REQ-015 SHALL have port m_index  output  clog2(N)  coefficient index, 0..N-1.
REQ-016 SHALL have port m_last  output  1  high with the beat at index N-1.

Function
REQ-017 SHALL implement the states IDLE, RD, CAP, LO, HI and FIN.
REQ-018 IDLE: when start is high, SHALL go to RD with word address 0; start SHALL be ignored in every other state.
REQ-019 RD: SHALL drive ram_rd_en=1 and ram_rd_addr=word address for one cycle, then go to CAP.
REQ-020 CAP: SHALL latch ram_data_in into a word register, then go to LO.
REQ-021 LO: SHALL drive m_valid=1, m_data=word[COEFF_WIDTH-1:0] and m_index=2*addr; on m_ready it SHALL go to HI.
REQ-022 HI: SHALL drive m_valid=1, m_data=word[2*COEFF_WIDTH-1:COEFF_WIDTH] and m_index=2*addr+1; on m_ready it SHALL go to FIN if addr=N/2-1, otherwise to RD with addr+1.
REQ-023 FIN: SHALL pulse done=1 for one cycle with busy=0, then go to IDLE.
REQ-024 A beat SHALL transfer only when m_valid and m_ready are both high in the same cycle.
REQ-025 While m_valid=1 and m_ready=0, m_data, m_index and m_last SHALL hold stable.
REQ-026 The first m_valid SHALL occur 3 cycles after the start edge (RD, CAP, LO).
REQ-027 Throughput SHALL be 2 coefficients per 4 cycles with m_ready tied high.
REQ-028 A full drain SHALL take exactly 2N+1 cycles with m_ready tied high.
REQ-029 ram_rd_en SHALL be 0 outside RD.
REQ-030 m_valid SHALL be 0 outside LO and HI.
REQ-031 busy SHALL be 1 in RD, CAP, LO and HI.
REQ-032 m_last SHALL equal (state==HI && addr==N/2-1).

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE, addr=0, word=0, and set busy, done, ram_rd_en, m_valid and m_last to 0.
REQ-034 ram_rd_addr, m_data and m_index SHALL reset to 0.
REQ-035 Reset mid-drain SHALL abandon the transfer without a done pulse.
REQ-036 A start after reset mid-drain SHALL restart from address 0.

Configuration
REQ-037 With macro SPM_RES_MODQ_EN defined, m_data SHALL be (c>=Q ? c-Q : c) for the selected raw coefficient c, computed combinationally within the same cycle.
REQ-038 With SPM_RES_MODQ_EN undefined, m_data SHALL be the raw coefficient c and no comparator SHALL be synthesized.

Verification
REQ-039 Drain test: load RAM word k = {(2k+1)%251, (2k)%251} and hold m_ready=1, pulse start -> 1024 beats with m_data=(index%251), m_last only at index 1023, done exactly 2049 cycles after start.
REQ-040 Backpressure test: toggle m_ready pseudo-randomly -> same beat sequence as the drain test, no dropped or duplicated index, outputs stable while stalled.
REQ-041 Start-while-busy test: pulse start again at beat 100 -> drain is unaffected and exactly one done is produced.
REQ-042 Reset test: assert rst at beat 300, then release and pulse start -> all outputs 0 immediately, no done, new drain begins at index 0.
REQ-043 Mod-Q test: load word 0 = 0xFCFB -> with SPM_RES_MODQ_EN beats 0x00 and 0x01; without it beats 0xFB and 0xFC.
REQ-044 Read-port test: monitor ram_rd_en -> exactly 512 single-cycle reads, addresses 0..511 strictly ascending.
